// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator and its pwm_counter measurement counterpart.
package pwm_pkg;

    localparam int PWM_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/pwm_generator.sv
// Fixed-frequency PWM source with period/high-time shadows reloaded only at period boundaries.
// Optional period_tick output is built when PWM_GEN_TICK_EN is defined.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] dty,
    output logic             PWM,
    output logic             busy
`ifdef PWM_GEN_TICK_EN
    ,
    output logic             period_tick
`endif
);

    pwm_state_t       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_s_q, period_s_d;
    logic [WIDTH-1:0] dty_s_q, dty_s_d;
    logic             pwm_q, pwm_d;
    logic             busy_q, busy_d;
    logic             tick_d;
    logic             at_last;
    logic             restart;
    logic [WIDTH-1:0] cnt_inc;

    // cnt_q is the period position whose output level PWM currently shows,
    // so the first level of a new period is driven from the freshly sampled dty.
    always_comb begin
        at_last = (period_s_q != '0) && (cnt_q == period_s_q - WIDTH'(1));
        restart = en && (period != '0);
        cnt_inc = cnt_q + WIDTH'(1);

        state_d    = state_q;
        cnt_d      = cnt_q;
        period_s_d = period_s_q;
        dty_s_d    = dty_s_q;
        pwm_d      = pwm_q;
        tick_d     = 1'b0;

        case (state_q)
            IDLE: begin
                period_s_d = period;
                dty_s_d    = dty;
                cnt_d      = '0;
                pwm_d      = 1'b0;
                if (restart) begin
                    state_d = RUN;
                    pwm_d   = (dty != '0);
                    tick_d  = 1'b1;
                end
            end
            RUN, DRAIN: begin
                if (at_last) begin
                    period_s_d = period;
                    dty_s_d    = dty;
                    cnt_d      = '0;
                    if (restart) begin
                        state_d = RUN;
                        pwm_d   = (dty != '0);
                        tick_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        pwm_d   = 1'b0;
                    end
                end else begin
                    cnt_d   = cnt_inc;
                    pwm_d   = (cnt_inc < dty_s_q);
                    state_d = en ? RUN : DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                pwm_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            period_s_q <= '0;
            dty_s_q    <= '0;
            pwm_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_s_q <= period_s_d;
            dty_s_q    <= dty_s_d;
            pwm_q      <= pwm_d;
            busy_q     <= busy_d;
        end
    end

    assign PWM  = pwm_q;
    assign busy = busy_q;

`ifdef PWM_GEN_TICK_EN
    logic tick_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign period_tick = tick_q;
`else
    logic unused_tick;
    assign unused_tick = tick_d;
`endif

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator: waveform shape, shadow timing, drain, stop and reset.
module tb_pwm_generator;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] period;
    logic [15:0] dty;
    logic        PWM;
    logic        busy;
`ifdef PWM_GEN_TICK_EN
    logic        period_tick;
`endif

    int total = 0;
    int bad   = 0;

    pwm_generator #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .period (period),
        .dty    (dty),
        .PWM    (PWM),
        .busy   (busy)
`ifdef PWM_GEN_TICK_EN
        ,
        .period_tick (period_tick)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks n consecutive cycles of constant PWM/busy; t0 is the expected tick on the first one.
    task automatic expect_cycles(input string tag, input int n, input logic p, input logic b,
                                 input logic t0);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_pwm"}, PWM, p);
            chk({tag, "_busy"}, busy, b);
`ifdef PWM_GEN_TICK_EN
            chk({tag, "_tick"}, period_tick, (i == 0) ? t0 : 1'b0);
`endif
            step();
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b1;
        period = 16'd200;
        dty    = 16'd100;
        repeat (3) step();
        chk("rst_pwm", PWM, 1'b0);
        chk("rst_busy", busy, 1'b0);
`ifdef PWM_GEN_TICK_EN
        chk("rst_tick", period_tick, 1'b0);
`endif

        // 200/100 from reset release; this cycle is T0
        rst_n = 1'b1;
        expect_cycles("t1_t0", 1, 1'b0, 1'b0, 1'b0);
        expect_cycles("t1_hi", 100, 1'b1, 1'b1, 1'b1);
        expect_cycles("t1_lo", 100, 1'b0, 1'b1, 1'b0);

        // mid-period duty changes only apply from the next period
        expect_cycles("t2_p2hi_a", 20, 1'b1, 1'b1, 1'b1);
        dty = 16'd50;
        expect_cycles("t2_p2hi_b", 80, 1'b1, 1'b1, 1'b0);
        expect_cycles("t2_p2lo", 100, 1'b0, 1'b1, 1'b0);
        expect_cycles("t2_p3hi_a", 20, 1'b1, 1'b1, 1'b1);
        dty = 16'd150;
        expect_cycles("t2_p3hi_b", 30, 1'b1, 1'b1, 1'b0);
        expect_cycles("t2_p3lo", 150, 0, 1'b1, 1'b0);
        expect_cycles("t2_p4hi_a", 20, 1'b1, 1'b1, 1'b1);
        period = 16'd10;
        dty    = 16'd0;
        expect_cycles("t2_p4hi_b", 130, 1'b1, 1'b1, 1'b0);
        expect_cycles("t2_p4lo", 50, 1'b0, 1'b1, 1'b0);

        // period 10 with duty 0, 10 and 65535
        dty = 16'd10;
        expect_cycles("t3_d0", 10, 1'b0, 1'b1, 1'b1);
        dty = 16'hFFFF;
        expect_cycles("t3_d10", 10, 1'b1, 1'b1, 1'b1);
        period = 16'd100;
        dty    = 16'd40;
        expect_cycles("t3_dmax", 10, 1'b1, 1'b1, 1'b1);

        // en dropped at cnt 30: period completes, then idle
        expect_cycles("t4_hi_a", 30, 1'b1, 1'b1, 1'b1);
        en = 1'b0;
        expect_cycles("t4_hi_b", 10, 1'b1, 1'b1, 1'b0);
        expect_cycles("t4_lo_a", 60, 1'b0, 1'b1, 1'b0);
        expect_cycles("t4_idle", 5, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        expect_cycles("t4_t0", 1, 1'b0, 1'b0, 1'b0);

        // en dropped at cnt 30 and re-raised at cnt 60: no gap
        expect_cycles("t4_hi_c", 30, 1'b1, 1'b1, 1'b1);
        en = 1'b0;
        expect_cycles("t4_hi_d", 10, 1'b1, 1'b1, 1'b0);
        expect_cycles("t4_lo_b", 20, 1'b0, 1'b1, 1'b0);
        en = 1'b1;
        expect_cycles("t4_lo_c", 40, 1'b0, 1'b1, 1'b0);

        // period written to 0 while running stops at the boundary despite en
        expect_cycles("t5_hi_a", 10, 1'b1, 1'b1, 1'b1);
        period = 16'd0;
        expect_cycles("t5_hi_b", 30, 1'b1, 1'b1, 1'b0);
        expect_cycles("t5_lo", 60, 1'b0, 1'b1, 1'b0);
        expect_cycles("t5_idle", 5, 1'b0, 1'b0, 1'b0);

        // asynchronous reset at cnt 5 while high, then restart from T0
        period = 16'd20;
        dty    = 16'd10;
        expect_cycles("t6_t0", 1, 1'b0, 1'b0, 1'b0);
        expect_cycles("t6_hi_a", 5, 1'b1, 1'b1, 1'b1);
        chk("t6_pre_pwm", PWM, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_pwm", PWM, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
`ifdef PWM_GEN_TICK_EN
        chk("t6_rst_tick", period_tick, 1'b0);
`endif
        step();
        rst_n = 1'b1;
        expect_cycles("t6_t0b", 1, 1'b0, 1'b0, 1'b0);
        expect_cycles("t6_hi_b", 10, 1'b1, 1'b1, 1'b1);
        expect_cycles("t6_lo_b", 10, 1'b0, 1'b1, 1'b0);
        expect_cycles("t6_hi_c", 10, 1'b1, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_generator.md
# pwm_generator

Generates a fixed-frequency PWM output from a period and a high-time count, both expressed in `clk` cycles. It is the output-side counterpart of the `pwm_counter` input measurement block. The register interface presents a period and a high time, and this block produces a waveform that `pwm_counter` would read back as the same values. New settings are double-buffered and take effect only at a period boundary, so the output never emits a glitched or truncated cycle.

## Interface
- `WIDTH`, 16: width of the period and duty counters.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `en`  in  1  run request, level-sensitive.
- `period`  in  WIDTH  PWM period in `clk` cycles; 0 means off.
- `dty`  in  WIDTH  high time in `clk` cycles.
- `PWM`  out  1  PWM output, registered.
- `busy`  out  1  high while in RUN or DRAIN.
- `period_tick`  out  1  one-cycle pulse at the start of each period. Present only with `PWM_GEN_TICK_EN`.

## Operation
- Internal registers:
  - `cnt` (WIDTH bits)
  - shadow registers `period_s` and `dty_s`
  - `state` ∈ {IDLE, RUN, DRAIN}
- IDLE:
  - `cnt` = 0 and `PWM` = 0.
  - Shadows load `period`/`dty` every cycle.
  - If `en` = 1 and `period` != 0, go to RUN.
- RUN, each cycle:
  - `PWM` <= (`cnt` < `dty_s`).
  - If `cnt` == `period_s` − 1: `cnt` <= 0, reload the shadows from the inputs, and raise the period-boundary event.
  - Otherwise `cnt` <= `cnt` + 1.
- RUN → DRAIN: when `en` falls. The current period completes with the old shadows.
- DRAIN behaves like RUN, except at the boundary it goes to IDLE with `PWM` <= 0.
  - If `en` rises again during DRAIN, the state returns to RUN at that boundary instead. There is no restart gap.
- At a boundary where the newly sampled `period` == 0, go to IDLE regardless of `en`.
- Comparison is unsigned, full WIDTH. No arithmetic wider than WIDTH; `period_s` − 1 is evaluated only when `period_s` != 0.
- Edge cases:
  - `dty_s` == 0: output is constantly low.
  - `dty_s` >= `period_s`: output is constantly high, with no low cycle.
  - `period_s` == 1: the output is `dty_s` != 0, constant.

## Timing
- Reset values: `state` = IDLE, `cnt` = 0, shadows = 0, `PWM` = 0, `busy` = 0, `period_tick` = 0.
- Start sequence:
  - Cycle T0: `en` = 1 is sampled in IDLE; shadows load and `cnt` = 0.
  - Cycle T1: the first `PWM` value appears, which is (0 < `dty_s`).
- Waveform: high for exactly `dty_s` cycles, then low for `period_s` − `dty_s` cycles.
- Latency: input changes are sampled at the last cycle of the current period and are visible on `PWM` in the cycle after.
- Mid-period changes to `period`/`dty` have no effect until the boundary.
- `busy` is asserted in the cycle after the T0 edge and drops in the same cycle `PWM` returns to the IDLE 0.
- If `rst_n` is asserted mid-period, all outputs go immediately (asynchronously) to their reset values.

## Configuration
- `PWM_GEN_TICK_EN` defined:
  - The `period_tick` port exists.
  - It pulses for one cycle, aligned with the first output cycle of each period: T1, and the cycle after every boundary that stays in RUN/DRAIN.
- Not defined: the port and its logic are absent. The rest of the behaviour is identical.

## Structure
- Shared package `pwm_pkg` holds:
  - the state enum `pwm_state_t` {IDLE, RUN, DRAIN}
  - the default `PWM_WIDTH` = 16, shared with `pwm_counter`.
- Single module, no sub-module. The counter and shadow logic are too small to split.

## Test plan
1. `period` = 200, `dty` = 100, `en` = 1 from reset release → `PWM` is 100 high / 100 low, first rise at T1. A `pwm_counter` loopback reports period 200 and high time 100.
2. `dty` changed from 50 to 150 at mid-period (`cnt` = 20, `period` = 200) → the current period stays 50 high; the next period is 150 high. No glitch.
3. Boundary values with `period` = 10 → `dty` = 0 gives constant low; `dty` = 10 and `dty` = 65535 give constant high; `busy` = 1 throughout.
4. `en` dropped at `cnt` = 30 (`period` = 100, `dty` = 40) → the period completes, `PWM` = 0 and `busy` = 0 after the 100th cycle. `en` re-raised at `cnt` = 60 → continuous next period.
5. `period` written to 0 while running → the output stops at the next boundary even with `en` = 1.
6. `rst_n` pulsed low at `cnt` = 5 while `PWM` = 1 → `PWM`, `busy` and `period_tick` go to 0 immediately. After release with `en` = 1, the block restarts from T0. With `PWM_GEN_TICK_EN`, exactly one tick per period is seen.
